// File: rtl/pause_pkg.sv
// ---------------------------------------------------------------------------
// pause_pkg
// Shared definitions for the TX MAC-control scheduler:
//   - schedState_t : scheduler state encoding (IDLE, CLIENT, PAUSE_TX)
//   - PAUSE_DA, MAC_CTRL_TYPE, PAUSE_OPCODE : fixed PAUSE frame header fields
//   - PAUSE_LEN / PAUSE_LAST : PAUSE frame length (FCS excluded) and last index
// ---------------------------------------------------------------------------
package pause_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLIENT   = 2'd1,
      PAUSE_TX = 2'd2
   } schedState_t;

   localparam logic [47:0] PAUSE_DA      = 48'h0180C2000001;
   localparam logic [15:0] MAC_CTRL_TYPE = 16'h8808;
   localparam logic [15:0] PAUSE_OPCODE  = 16'h0001;

   localparam int          PAUSE_LEN  = 60;
   localparam logic [5:0]  PAUSE_LAST = 6'(PAUSE_LEN - 1);

endpackage

// File: rtl/pause_tx_sched_if.sv
// ---------------------------------------------------------------------------
// pause_tx_sched_if
// Byte-stream bundle around the scheduler.
//   cl_*  : client TX stream into the scheduler (cl_ready flows back)
//   mac_* : scheduled stream towards the TX MAC (mac_ready flows back)
// Modports:
//   master : environment side (drives client bytes and mac_ready)
//   slave  : scheduler side (drives cl_ready and the mac_* stream)
// ---------------------------------------------------------------------------
interface pause_tx_sched_if;
   logic [7:0] cl_data;
   logic       cl_valid;
   logic       cl_sof;
   logic       cl_eof;
   logic       cl_ready;
   logic [7:0] mac_data;
   logic       mac_valid;
   logic       mac_sof;
   logic       mac_eof;
   logic       mac_ready;

   modport master (
      output cl_data, cl_valid, cl_sof, cl_eof, mac_ready,
      input  cl_ready, mac_data, mac_valid, mac_sof, mac_eof
   );

   modport slave (
      input  cl_data, cl_valid, cl_sof, cl_eof, mac_ready,
      output cl_ready, mac_data, mac_valid, mac_sof, mac_eof
   );
endinterface

// File: rtl/pause_frame_rom.sv
// ---------------------------------------------------------------------------
// pause_frame_rom
// Combinational byte generator for a 60-byte PAUSE frame.
//   byteIdx     : in  6  byte position 0..59
//   stationAddr : in  48 source address, MS byte first
//   quanta      : in  16 pause quanta, MS byte first
//   byteVal     : out 8  frame byte at byteIdx (pad bytes 18..59 are zero)
// ---------------------------------------------------------------------------
module pause_frame_rom
   import pause_pkg::*;
(
   input  logic [5:0]  byteIdx,
   input  logic [47:0] stationAddr,
   input  logic [15:0] quanta,
   output logic [7:0]  byteVal
);

   always_comb begin
      byteVal = 8'h00;
      case (byteIdx)
         6'd0:    byteVal = PAUSE_DA[47:40];
         6'd1:    byteVal = PAUSE_DA[39:32];
         6'd2:    byteVal = PAUSE_DA[31:24];
         6'd3:    byteVal = PAUSE_DA[23:16];
         6'd4:    byteVal = PAUSE_DA[15:8];
         6'd5:    byteVal = PAUSE_DA[7:0];
         6'd6:    byteVal = stationAddr[47:40];
         6'd7:    byteVal = stationAddr[39:32];
         6'd8:    byteVal = stationAddr[31:24];
         6'd9:    byteVal = stationAddr[23:16];
         6'd10:   byteVal = stationAddr[15:8];
         6'd11:   byteVal = stationAddr[7:0];
         6'd12:   byteVal = MAC_CTRL_TYPE[15:8];
         6'd13:   byteVal = MAC_CTRL_TYPE[7:0];
         6'd14:   byteVal = PAUSE_OPCODE[15:8];
         6'd15:   byteVal = PAUSE_OPCODE[7:0];
         6'd16:   byteVal = quanta[15:8];
         6'd17:   byteVal = quanta[7:0];
         default: byteVal = 8'h00;
      endcase
   end

endmodule

// File: rtl/pause_tx_sched.sv
// ---------------------------------------------------------------------------
// pause_tx_sched
// TX MAC-control scheduler: arbitrates the TX MAC byte stream between client
// frames and locally generated PAUSE frames, holds off client frame starts
// while the RX pause detector is active, and schedules XOFF / refresh PAUSE
// frames from the RX FIFO flow-control request.
//
// Ports:
//   clk, rst        : MAC TX clock, asynchronous active-high reset
//   clk_en          : byte-rate enable; state advances only when high
//   slot_tick       : one pulse per 512 bit times (refresh timer base)
//   station_addr    : PAUSE source address
//   pause_quanta    : quanta carried by XOFF frames
//   refresh_time    : XOFF refresh interval in slots, 0 disables refresh
//   xoff_req        : level flow-control request from RX FIFO
//   rx_pause_active : blocks client frame starts (never PAUSE frames)
//   txIf (slave)    : client stream in (cl_*), MAC stream out (mac_*)
//   pause_sent      : pulse on transfer of the last PAUSE byte
//   stray_err       : pulse when a non-SOF client byte is dropped in IDLE
//
// Build option: define PAUSE_XON_EN to send an XON frame (quanta 0) on the
// falling edge of xoff_req; otherwise the falling edge only cancels a
// pending XOFF.
// ---------------------------------------------------------------------------
module pause_tx_sched
   import pause_pkg::*;
#(
   parameter int DLY       = 1,
   parameter int REFRESH_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 slot_tick,
   input  logic [47:0]          station_addr,
   input  logic [15:0]          pause_quanta,
   input  logic [REFRESH_W-1:0] refresh_time,
   input  logic                 xoff_req,
   input  logic                 rx_pause_active,
   pause_tx_sched_if.slave      txIf,
   output logic                 pause_sent,
   output logic                 stray_err
);

   localparam logic [REFRESH_W-1:0] TmrOne = REFRESH_W'(1);

   // DLY is accepted for drop-in compatibility with existing instantiations;
   // the flops below are zero-delay.
   if (DLY < 0) begin : gDlyUnused
   end

   schedState_t          state;
   logic [5:0]           byteCnt;
   logic                 pendXoff;
   logic                 xoffReqQ;
   logic [REFRESH_W-1:0] refreshTmr;
   logic [15:0]          txQuanta;
   logic [7:0]           romByte;

   logic pendAny;
   logic clXfer;
   logic xoffRise;
   logic xoffFall;
   logic lastXfer;
   logic xoffSent;
   logic refreshOn;
   logic refreshHit;
   logic refreshInc;

`ifdef PAUSE_XON_EN
   logic pendXon;
   logic txIsXoff;
   assign pendAny  = pendXoff | pendXon;
   assign xoffSent = lastXfer & txIsXoff;
`else
   assign pendAny  = pendXoff;
   assign xoffSent = lastXfer;
`endif

   assign clXfer     = clk_en & txIf.cl_valid & txIf.cl_ready;
   assign xoffRise   = xoff_req & ~xoffReqQ;
   assign xoffFall   = ~xoff_req & xoffReqQ;
   assign lastXfer   = (state == PAUSE_TX) & clk_en & txIf.mac_ready &
                       (byteCnt == PAUSE_LAST);
   assign refreshOn  = slot_tick & xoff_req & (refresh_time != '0);
   assign refreshHit = refreshOn & (refreshTmr == refresh_time - TmrOne);
   assign refreshInc = refreshOn & (refreshTmr != '1);

   pause_frame_rom uRom (
      .byteIdx     (byteCnt),
      .stationAddr (station_addr),
      .quanta      (txQuanta),
      .byteVal     (romByte)
   );

   // Outputs follow the state registers; CLIENT is a zero-latency passthrough
   // so the client stream is never delayed.
   always_comb begin
      txIf.mac_data  = 8'h00;
      txIf.mac_valid = 1'b0;
      txIf.mac_sof   = 1'b0;
      txIf.mac_eof   = 1'b0;
      txIf.cl_ready  = 1'b0;
      stray_err      = 1'b0;
      pause_sent     = 1'b0;
      case (state)
         IDLE: begin
            // Stray (non-SOF) bytes are drained only when no PAUSE is due.
            if (!pendAny && txIf.cl_valid && !txIf.cl_sof) begin
               txIf.cl_ready = clk_en;
               stray_err     = clk_en;
            end
         end
         CLIENT: begin
            txIf.mac_data  = txIf.cl_data;
            txIf.mac_valid = txIf.cl_valid;
            txIf.mac_sof   = txIf.cl_sof;
            txIf.mac_eof   = txIf.cl_eof;
            txIf.cl_ready  = txIf.mac_ready & clk_en;
         end
         PAUSE_TX: begin
            txIf.mac_data  = romByte;
            txIf.mac_valid = 1'b1;
            txIf.mac_sof   = (byteCnt == 6'd0);
            txIf.mac_eof   = (byteCnt == PAUSE_LAST);
            pause_sent     = lastXfer;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         byteCnt    <= 6'd0;
         pendXoff   <= 1'b0;
         xoffReqQ   <= 1'b0;
         refreshTmr <= '0;
         txQuanta   <= 16'h0000;
`ifdef PAUSE_XON_EN
         pendXon    <= 1'b0;
         txIsXoff   <= 1'b0;
`endif
      end else if (clk_en) begin
         xoffReqQ <= xoff_req;

         case (state)
            IDLE: begin
               if (pendAny) begin
                  state   <= PAUSE_TX;
                  byteCnt <= 6'd0;
`ifdef PAUSE_XON_EN
                  txIsXoff <= pendXoff;
                  txQuanta <= pendXoff ? pause_quanta : 16'h0000;
`else
                  txQuanta <= pause_quanta;
`endif
               end else if (txIf.cl_valid && txIf.cl_sof && !rx_pause_active) begin
                  state <= CLIENT;
               end
            end
            CLIENT: begin
               if (clXfer && txIf.cl_eof) begin
                  state <= IDLE;
               end
            end
            PAUSE_TX: begin
               if (txIf.mac_ready) begin
                  if (byteCnt == PAUSE_LAST) begin
                     state   <= IDLE;
                     byteCnt <= 6'd0;
                  end else begin
                     byteCnt <= byteCnt + 6'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Served flag clears first; edges and refresh expiry seen in the
         // same cycle override it, so a new request is never lost.
`ifdef PAUSE_XON_EN
         if (lastXfer) begin
            if (txIsXoff) pendXoff <= 1'b0;
            else          pendXon  <= 1'b0;
         end
`else
         if (lastXfer) pendXoff <= 1'b0;
`endif
         if (refreshHit) pendXoff <= 1'b1;
         if (xoffRise) begin
            pendXoff <= 1'b1;
`ifdef PAUSE_XON_EN
            pendXon  <= 1'b0;
`endif
         end else if (xoffFall) begin
            pendXoff <= 1'b0;
`ifdef PAUSE_XON_EN
            pendXon  <= 1'b1;
`endif
         end

         // Refresh timer: counts slots while the request is held.
         if (xoffRise || xoffSent || refreshHit) begin
            refreshTmr <= '0;
         end else if (refreshInc) begin
            refreshTmr <= refreshTmr + TmrOne;
         end
      end
   end

endmodule

// File: tb/tb_pause_tx_sched.sv
`timescale 1ns/1ps
module tb_pause_tx_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        slot_tick;
   logic [47:0] station_addr;
   logic [15:0] pause_quanta;
   logic [15:0] refresh_time;
   logic        xoff_req;
   logic        rx_pause_active;
   logic        pause_sent;
   logic        stray_err;

   pause_tx_sched_if bus ();

   pause_tx_sched #(.DLY(1), .REFRESH_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .clk_en          (clk_en),
      .slot_tick       (slot_tick),
      .station_addr    (station_addr),
      .pause_quanta    (pause_quanta),
      .refresh_time    (refresh_time),
      .xoff_req        (xoff_req),
      .rx_pause_active (rx_pause_active),
      .txIf            (bus),
      .pause_sent      (pause_sent),
      .stray_err       (stray_err)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic [9:0] expQ[$];   // {sof, eof, data} expected on the MAC side
   logic [9:0] clQ[$];    // {sof, eof, data} client bytes still to offer
   int         sofTicks[$];

   int pauseSentCnt     = 0;
   int expSent          = 0;
   int strayCnt         = 0;
   int readyWhilePaused = 0;
   int unexpected       = 0;
   int ticksSinceSent   = 0;
   int slotPeriod       = 0;
   int slotCnt          = 0;
   bit rndReady         = 1'b0;
   bit rndEn            = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent reference for the PAUSE frame contents.
   function automatic logic [7:0] pauseByte(input int i, input logic [15:0] q);
      logic [143:0] hdr;
      hdr = {48'h0180C2000001, station_addr, 16'h8808, 16'h0001, q};
      if (i < 18) return hdr[8*(17-i) +: 8];
      return 8'h00;
   endfunction

   task automatic pushPause(input logic [15:0] q, input int nBytes);
      for (int i = 0; i < nBytes; i++)
         expQ.push_back({(i == 0), (i == 59), pauseByte(i, q)});
      if (nBytes == 60) expSent++;
   endtask

   task automatic pushClient(input int len, input int seed);
      logic [9:0] b;
      for (int i = 0; i < len; i++) begin
         b = {(i == 0), (i == len - 1), 8'(i * 3 + seed)};
         clQ.push_back(b);
         expQ.push_back(b);
      end
   endtask

   task automatic monitor();
      logic [9:0] got;
      logic [9:0] exp;
      if (rx_pause_active && bus.cl_ready) readyWhilePaused++;
      if (stray_err) strayCnt++;
      if (clk_en && bus.mac_valid && bus.mac_ready) begin
         got = {bus.mac_sof, bus.mac_eof, bus.mac_data};
         if (got[9]) sofTicks.push_back(ticksSinceSent);
         if (expQ.size() == 0) unexpected++;
         else begin
            exp = expQ.pop_front();
            check("mac_byte", 64'(got), 64'(exp));
         end
      end
      if (pause_sent) begin
         pauseSentCnt++;
         ticksSinceSent = 0;
      end else if (clk_en && slot_tick) begin
         ticksSinceSent++;
      end
   endtask

   task automatic cyc();
      logic [9:0] hd;
      if (clQ.size() > 0) begin
         hd = clQ[0];
         bus.cl_valid = 1'b1;
         bus.cl_sof   = hd[9];
         bus.cl_eof   = hd[8];
         bus.cl_data  = hd[7:0];
      end else begin
         bus.cl_valid = 1'b0;
         bus.cl_sof   = 1'b0;
         bus.cl_eof   = 1'b0;
         bus.cl_data  = 8'h00;
      end
      bus.mac_ready = rndReady ? 1'($urandom_range(0, 1)) : 1'b1;
      clk_en        = rndEn ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (slotPeriod > 0) begin
         slot_tick = (slotCnt == slotPeriod - 1);
         slotCnt   = (slotCnt + 1) % slotPeriod;
      end else begin
         slot_tick = 1'b0;
      end
      @(negedge clk);
      monitor();
      if (clk_en && bus.cl_valid && bus.cl_ready) void'(clQ.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((expQ.size() > 0 || clQ.size() > 0) && n < budget) begin
         cyc();
         n++;
      end
      check(tag, 64'(expQ.size() + clQ.size()), 64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int n;
      int base;
      rst             = 1'b1;
      clk_en          = 1'b0;
      slot_tick       = 1'b0;
      station_addr    = 48'h001122334455;
      pause_quanta    = 16'h1234;
      refresh_time    = 16'd0;
      xoff_req        = 1'b0;
      rx_pause_active = 1'b0;
      bus.cl_data     = 8'h00;
      bus.cl_valid    = 1'b0;
      bus.cl_sof      = 1'b0;
      bus.cl_eof      = 1'b0;
      bus.mac_ready   = 1'b1;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("rst_mac_valid", 64'(bus.mac_valid), 64'd0);
      check("rst_mac_data", 64'(bus.mac_data), 64'h00);
      check("rst_mac_sof_eof", 64'({bus.mac_sof, bus.mac_eof}), 64'd0);
      check("rst_cl_ready", 64'(bus.cl_ready), 64'd0);
      check("rst_pulses", 64'({pause_sent, stray_err}), 64'd0);
      rst = 1'b0;
      idle(3);

      // XOFF frame from IDLE
      xoff_req = 1'b1;
      pushPause(16'h1234, 60);
      drain("xoff_drain", 200);
      check("xoff_sent_cnt", 64'(pauseSentCnt), 64'(expSent));
      xoff_req = 1'b0;
`ifdef PAUSE_XON_EN
      pushPause(16'h0000, 60);
`endif
      idle(80);
      check("fall_drain", 64'(expQ.size()), 64'd0);
      check("fall_sent_cnt", 64'(pauseSentCnt), 64'(expSent));

      // Stray non-SOF byte in IDLE is dropped with stray_err
      clQ.push_back({1'b0, 1'b0, 8'h5A});
      idle(2);
      check("stray_cnt", 64'(strayCnt), 64'd1);
      check("stray_popped", 64'(clQ.size()), 64'd0);

      // XOFF raised mid client frame, random ready/enable
      pause_quanta = 16'hABCD;
      rndReady     = 1'b1;
      rndEn        = 1'b1;
      pushClient(64, 7);
      n = 0;
      while (clQ.size() > 44 && n < 500) begin cyc(); n++; end
      check("mid_frame_reached", 64'(clQ.size() <= 44), 64'd1);
      xoff_req = 1'b1;
      pushPause(16'hABCD, 60);
      drain("client_pause_drain", 1500);
      check("client_sent_cnt", 64'(pauseSentCnt), 64'(expSent));
      xoff_req = 1'b0;
`ifdef PAUSE_XON_EN
      pushPause(16'h0000, 60);
`endif
      drain("client_fall_drain", 1000);
      rndReady = 1'b0;
      rndEn    = 1'b0;
      idle(4);

      // rx_pause_active holds the client, not the PAUSE frame
      rx_pause_active  = 1'b1;
      readyWhilePaused = 0;
      clQ.push_back({1'b1, 1'b0, 8'hC1});
      clQ.push_back({1'b0, 1'b1, 8'hC2});
      idle(5);
      check("paused_client_held", 64'(clQ.size()), 64'd2);
      xoff_req = 1'b1;
      pushPause(16'hABCD, 60);
      expQ.push_back({1'b1, 1'b0, 8'hC1});
      expQ.push_back({1'b0, 1'b1, 8'hC2});
      base = pauseSentCnt;
      n = 0;
      while (pauseSentCnt == base && n < 200) begin cyc(); n++; end
      check("paused_pause_sent", 64'(pauseSentCnt), 64'(base + 1));
      check("paused_cl_ready", 64'(readyWhilePaused), 64'd0);
      rx_pause_active = 1'b0;
      drain("paused_drain", 50);
      xoff_req = 1'b0;
`ifdef PAUSE_XON_EN
      pushPause(16'h0000, 60);
`endif
      drain("paused_fall_drain", 200);
      idle(4);

      // Refresh: second XOFF 4 slot ticks after the first pause_sent
      pause_quanta = 16'h00FF;
      refresh_time = 16'd4;
      slotPeriod   = 10;
      slotCnt      = 0;
      sofTicks.delete();
      xoff_req     = 1'b1;
      pushPause(16'h00FF, 60);
      pushPause(16'h00FF, 60);
      base = pauseSentCnt;
      n = 0;
      while (pauseSentCnt < base + 2 && n < 600) begin cyc(); n++; end
      check("refresh_sent_cnt", 64'(pauseSentCnt), 64'(base + 2));
      xoff_req = 1'b0;
`ifdef PAUSE_XON_EN
      pushPause(16'h0000, 60);
`endif
      drain("refresh_drain", 300);
      idle(60);
`ifdef PAUSE_XON_EN
      check("refresh_frames", 64'(sofTicks.size()), 64'd3);
`else
      check("refresh_frames", 64'(sofTicks.size()), 64'd2);
`endif
      if (sofTicks.size() >= 2) check("refresh_ticks", 64'(sofTicks[1]), 64'd4);
      slotPeriod   = 0;
      refresh_time = 16'd0;
      idle(4);

      // Async reset at PAUSE byte 30 with toggling mac_ready
      pause_quanta = 16'h1234;
      rndReady     = 1'b1;
      xoff_req     = 1'b1;
      pushPause(16'h1234, 30);
      drain("rst_partial_drain", 300);
      rst = 1'b1;
      #1;
      check("rst_mid_valid", 64'(bus.mac_valid), 64'd0);
      check("rst_mid_sof", 64'(bus.mac_sof), 64'd0);
      check("rst_mid_data", 64'(bus.mac_data), 64'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      pushPause(16'h1234, 60);
      drain("rst_restart_drain", 400);
      check("rst_sent_cnt", 64'(pauseSentCnt), 64'(expSent));
      rndReady = 1'b0;
      xoff_req = 1'b0;
`ifdef PAUSE_XON_EN
      pushPause(16'h0000, 60);
`endif
      drain("final_drain", 200);
      idle(70);

      check("unexpected_bytes", 64'(unexpected), 64'd0);
      check("final_sent_cnt", 64'(pauseSentCnt), 64'(expSent));
      check("final_stray_cnt", 64'(strayCnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
